// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for the 8-bit multicycle MIPS datapath.
// Optional illegal-instruction trap enabled by defining MIPS_CTRL_ILLEGAL_TRAP_EN.
module mips_multicycle_controller #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LB    = 6'b100000,
  parameter logic [5:0] OP_SB    = 6'b101000,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic [3:0] irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucont,
  output logic [1:0] pcsource,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14,
    S_HALT    = 4'd15
  } state_t;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  localparam state_t S_ILLEGAL_NEXT = S_HALT;
`else
  localparam state_t S_ILLEGAL_NEXT = S_FETCH1;
`endif

  state_t state_q;
  state_t state_d;
  logic   pcwrite_s;
  logic   branch_s;
  logic [3:0] funct_dec_s;

  // Returns {valid, alucont}; unknown functions fall back to add.
  function automatic logic [3:0] decode_funct(input logic [5:0] f);
    logic [3:0] r;
    case (f)
      6'd32:   r = 4'b1_010;
      6'd34:   r = 4'b1_110;
      6'd36:   r = 4'b1_000;
      6'd37:   r = 4'b1_001;
      6'd42:   r = 4'b1_111;
      default: r = 4'b0_010;
    endcase
    return r;
  endfunction

  assign funct_dec_s = decode_funct(funct);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH1;
    case (state_q)
      S_FETCH1:  state_d = S_FETCH2;
      S_FETCH2:  state_d = S_FETCH3;
      S_FETCH3:  state_d = S_FETCH4;
      S_FETCH4:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LB) begin
          state_d = S_LBRD;
        end else begin
          state_d = S_SBWR;
        end
      end
      S_LBRD:    state_d = S_LBWR;
      S_LBWR:    state_d = S_FETCH1;
      S_SBWR:    state_d = S_FETCH1;
      S_RTYPEEX: begin
        if (funct_dec_s[3]) begin
          state_d = S_RTYPEWR;
        end else begin
          state_d = S_ILLEGAL_NEXT;
        end
      end
      S_RTYPEWR: state_d = S_FETCH1;
      S_BEQEX:   state_d = S_FETCH1;
      S_JEX:     state_d = S_FETCH1;
      S_ADDIEX:  state_d = S_ADDIWR;
      S_ADDIWR:  state_d = S_FETCH1;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      S_HALT:    state_d = S_HALT;
`else
      S_HALT:    state_d = S_FETCH1;
`endif
      default:   state_d = S_FETCH1;
    endcase
  end

  // Moore output decode; only pcen looks at the live zero flag.
  always_comb begin
    pcwrite_s = 1'b0;
    branch_s  = 1'b0;
    iord      = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 4'b0000;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    alucont   = 3'b010;
    pcsource  = 2'b00;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH1: begin
        irwrite   = 4'b0001;
        alusrcb   = 2'b01;
        pcwrite_s = 1'b1;
      end
      S_FETCH2: begin
        irwrite   = 4'b0010;
        alusrcb   = 2'b01;
        pcwrite_s = 1'b1;
      end
      S_FETCH3: begin
        irwrite   = 4'b0100;
        alusrcb   = 2'b01;
        pcwrite_s = 1'b1;
      end
      S_FETCH4: begin
        irwrite   = 4'b1000;
        alusrcb   = 2'b01;
        pcwrite_s = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_LBRD:   iord = 1'b1;
      S_LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_SBWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        alucont = funct_dec_s[2:0];
      end
      S_RTYPEWR: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b00;
        alucont  = 3'b110;
        pcsource = 2'b01;
        branch_s = 1'b1;
      end
      S_JEX: begin
        pcwrite_s = 1'b1;
        pcsource  = 2'b10;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWR: regwrite = 1'b1;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      S_HALT:   illegal = 1'b1;
`else
      S_HALT:   illegal = 1'b0;
`endif
      default:  illegal = 1'b0;
    endcase
    pcen = pcwrite_s | (branch_s & zero);
  end

endmodule
